dma_burst_writer: RTL and testbench

//  Parametrised AXI3 write-only DMA master: buffers a valid/ready sample stream in an internal FIFO and

---
 rtl/dma_pkg.sv | 28 ++
 rtl/dma_sync_fifo.sv | 69 ++++++
 rtl/dma_burst_writer.sv | 231 +++++++++++++++++++++++
 tb/tb_dma_burst_writer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared FSM type, AXI3 codes and burst size helper for the DMA burst writer
//
// Purpose : common definitions imported by dma_sync_fifo and dma_burst_writer.
// Ports   : none (package).
package dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_t;

  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Bytes covered by one burst of len beats of data_w bits.
  function automatic logic [31:0] burst_bytes(input int unsigned len, input int unsigned data_w);
    return 32'(len * (data_w / 8));
  endfunction

endpackage

// File: rtl/dma_sync_fifo.sv
// rtl/dma_sync_fifo.sv - first-word-fall-through synchronous FIFO with flush
//
// Purpose : buffers stream beats ahead of the AXI write channel; o_rdata shows
//           the head entry combinationally whenever the FIFO is not empty.
// Ports   : i_clk, i_rst_n (async active-low)
//           i_flush            drop all contents (push in the same cycle is discarded)
//           i_push, i_wdata    write side
//           i_pop, o_rdata     read side (FWFT)
//           o_full, o_empty, o_count  occupancy, o_count is 0..DEPTH
module dma_sync_fifo
  import dma_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_full,
  output logic              o_empty,
  output logic [AW:0]       o_count
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_do_push;
  logic              w_do_pop;

  // DEPTH is a power of two, so the count MSB alone marks full.
  assign o_full    = r_count[AW];
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  // A push at full is accepted only when a pop frees the slot in the same cycle.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/dma_burst_writer.sv
// rtl/dma_burst_writer.sv - AXI3 write-only DMA master, stream in, fixed INCR bursts out
//
// Purpose : buffers a valid/ready sample stream and writes it to memory as
//           BURST_LEN-beat INCR bursts, linear (num_bursts then done) or circular
//           (wrap to base until stopped). An AW is only issued once a whole burst
//           is buffered, so W never stalls on the stream side.
// Macro   : DMA_RESP_CHECK_EN - bresp != OKAY enters ERROR and sets sticky err_o;
//           undefined: bresp ignored, err_o tied 0.
// Ports   : aclk, rst_ni (async active-low)
//           start_i/stop_i pulses, circ_i/base_addr_i/num_bursts_i sampled at start
//           s_data_i/s_valid_i/s_ready_o   input stream (ready = FIFO not full)
//           m_axi_aw*/w*/b*                AXI3 write channels
//           busy_o, done_o, burst_cnt_o, drop_cnt_o, err_o  status
module dma_burst_writer
  import dma_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int CNT_W      = 20
) (
  input  logic                aclk,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic                circ_i,
  input  logic [31:0]         base_addr_i,
  input  logic [CNT_W-1:0]    num_bursts_i,
  input  logic [DATA_W-1:0]   s_data_i,
  input  logic                s_valid_i,
  output logic                s_ready_o,
  output logic [31:0]         m_axi_awaddr,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [3:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  input  logic [1:0]          m_axi_bresp,
  output logic                busy_o,
  output logic                done_o,
  output logic [CNT_W-1:0]    burst_cnt_o,
  output logic [15:0]         drop_cnt_o,
  output logic                err_o
);

  localparam int                 FCNT_W         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0]        LP_BURST_BYTES = burst_bytes(BURST_LEN, DATA_W);
  localparam logic [FCNT_W-1:0]  LP_BURST_FILL  = FCNT_W'(BURST_LEN);
  localparam logic [3:0]         LP_LAST_BEAT   = 4'(BURST_LEN - 1);

  state_t             r_state;
  state_t             w_next;
  logic [31:0]        r_addr;
  logic [31:0]        r_base;
  logic [CNT_W-1:0]   r_num;
  logic               r_circ;
  logic [CNT_W-1:0]   r_burst_cnt;
  logic [3:0]         r_beat;
  logic               r_stop_pend;
  logic [15:0]        r_drop_cnt;

  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [FCNT_W-1:0]  w_fifo_count;
  logic [DATA_W-1:0]  w_fifo_rdata;

  logic               w_start_ok;
  logic               w_busy;
  logic               w_stop;
  logic               w_fill_ok;
  logic               w_w_hs;
  logic               w_b_err;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               w_last_pass;

  assign w_start_ok  = start_i && (num_bursts_i != '0) &&
                       ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERROR));
  assign w_busy      = (r_state == ST_ADDR) || (r_state == ST_DATA) || (r_state == ST_RESP);
  // A stop arriving in the same cycle as the deciding event counts as pending.
  assign w_stop      = r_stop_pend | stop_i;
  assign w_fill_ok   = (w_fifo_count >= LP_BURST_FILL);
  assign w_w_hs      = m_axi_wvalid & m_axi_wready;
  assign w_cnt_inc   = r_burst_cnt + CNT_W'(1);
  assign w_last_pass = (w_cnt_inc == r_num);

`ifdef DMA_RESP_CHECK_EN
  logic r_err;
  assign w_b_err = (m_axi_bresp != RESP_OKAY);
  assign err_o   = r_err;
`else
  logic w_unused_bresp;
  assign w_unused_bresp = ^m_axi_bresp;
  assign w_b_err        = 1'b0;
  assign err_o          = 1'b0;
`endif

  dma_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (aclk),
    .i_rst_n (rst_ni),
    .i_flush (w_start_ok),
    .i_push  (s_valid_i & s_ready_o),
    .i_wdata (s_data_i),
    .i_pop   (w_w_hs),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign s_ready_o     = ~w_fifo_full;
  assign m_axi_awaddr  = r_addr;
  assign m_axi_awlen   = LP_LAST_BEAT;
  assign m_axi_awsize  = 3'($clog2(DATA_W / 8));
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_wdata   = w_fifo_rdata;
  assign m_axi_wstrb   = '1;
  assign burst_cnt_o   = r_burst_cnt;
  assign drop_cnt_o    = r_drop_cnt;

  // State register
  always_ff @(posedge aclk or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE, ST_DONE: if (w_start_ok) w_next = ST_ADDR;
      // Stop before AW is offered ends cleanly with no partial burst.
      ST_ADDR: begin
        if (!w_fill_ok && w_stop)            w_next = ST_DONE;
        else if (w_fill_ok && m_axi_awready) w_next = ST_DATA;
      end
      ST_DATA: if (w_w_hs && (r_beat == LP_LAST_BEAT)) w_next = ST_RESP;
      ST_RESP: begin
        if (m_axi_bvalid) begin
          if (w_b_err)                       w_next = ST_ERROR;
          else if (w_stop)                   w_next = ST_DONE;
          else if (w_last_pass && !r_circ)   w_next = ST_DONE;
          else                               w_next = ST_ADDR;
        end
      end
`ifdef DMA_RESP_CHECK_EN
      ST_ERROR: if (w_start_ok) w_next = ST_ADDR;
`endif
      default: w_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    m_axi_bready  = 1'b0;
    busy_o        = w_busy;
    done_o        = (r_state == ST_DONE);
    case (r_state)
      // The FIFO cannot drain in ADDR, so awvalid stays up until awready once raised.
      ST_ADDR: m_axi_awvalid = w_fill_ok;
      ST_DATA: begin
        m_axi_wvalid = ~w_fifo_empty;
        m_axi_wlast  = ~w_fifo_empty && (r_beat == LP_LAST_BEAT);
      end
      ST_RESP: m_axi_bready = 1'b1;
      default: ;
    endcase
  end

  // Datapath: configuration, address, counters
  always_ff @(posedge aclk or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr      <= '0;
      r_base      <= '0;
      r_num       <= '0;
      r_circ      <= 1'b0;
      r_burst_cnt <= '0;
      r_beat      <= '0;
      r_stop_pend <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_start_ok) begin
        r_addr      <= base_addr_i;
        r_base      <= base_addr_i;
        r_num       <= num_bursts_i;
        r_circ      <= circ_i;
        r_burst_cnt <= '0;
        r_drop_cnt  <= '0;
      end else begin
        if (s_valid_i && !s_ready_o && (r_drop_cnt != 16'hFFFF))
          r_drop_cnt <= r_drop_cnt + 16'd1;
        if ((r_state == ST_RESP) && m_axi_bvalid && !w_b_err) begin
          if (w_last_pass && r_circ && !w_stop) begin
            r_addr      <= r_base;
            r_burst_cnt <= '0;
          end else begin
            r_addr      <= r_addr + LP_BURST_BYTES;
            r_burst_cnt <= w_cnt_inc;
          end
        end
      end

      if (r_state == ST_ADDR) r_beat <= '0;
      else if (w_w_hs)        r_beat <= r_beat + 4'd1;

      if (w_start_ok || (w_next == ST_DONE)) r_stop_pend <= 1'b0;
      else if (w_busy && stop_i)             r_stop_pend <= 1'b1;
    end
  end

`ifdef DMA_RESP_CHECK_EN
  always_ff @(posedge aclk or negedge rst_ni) begin
    if (!rst_ni)                                                   r_err <= 1'b0;
    else if (w_start_ok)                                           r_err <= 1'b0;
    else if ((r_state == ST_RESP) && m_axi_bvalid && w_b_err)      r_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_dma_burst_writer.sv
// tb/tb_dma_burst_writer.sv - directed self-checking bench for dma_burst_writer
module tb_dma_burst_writer;

  logic        aclk = 1'b0;
  logic        rst_ni;
  logic        start_i, stop_i, circ_i;
  logic [31:0] base_addr_i;
  logic [19:0] num_bursts_i;
  logic [63:0] s_data_i;
  logic        s_valid_i;
  logic        s_ready_o;
  logic [31:0] m_axi_awaddr;
  logic        m_axi_awvalid, m_axi_awready;
  logic [3:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic [63:0] m_axi_wdata;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic        m_axi_bvalid, m_axi_bready;
  logic [1:0]  m_axi_bresp;
  logic        busy_o, done_o, err_o;
  logic [19:0] burst_cnt_o;
  logic [15:0] drop_cnt_o;

  int total = 0;
  int bad   = 0;

  // slave / source knobs (written by the main sequence only)
  logic        aw_en = 1'b1, w_en = 1'b1, aw_rand = 1'b0, w_rand = 1'b0, src_on = 1'b0;
  int          src_limit = 0;
  int          err_burst = -1;
  logic [63:0] tag_base  = 64'h0;
  int          clr_req   = 0;

  // slave / source state (written by the responder process only)
  logic [31:0] aw_q[$];
  logic [63:0] w_q[$];
  int src_sent = 0, tb_drop = 0, wlast_err = 0, b_owed = 0, b_num = 0, clr_seen = 0;
  logic b_taken = 1'b0;

  always #5 aclk = ~aclk;

  dma_burst_writer dut (
    .aclk(aclk), .rst_ni(rst_ni), .start_i(start_i), .stop_i(stop_i), .circ_i(circ_i),
    .base_addr_i(base_addr_i), .num_bursts_i(num_bursts_i),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
    .busy_o(busy_o), .done_o(done_o), .burst_cnt_o(burst_cnt_o), .drop_cnt_o(drop_cnt_o),
    .err_o(err_o)
  );

  // AXI slave + stream source: observe at posedge, drive at negedge
  initial begin
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    s_valid_i = 1'b0; s_data_i = '0;
    forever begin
      @(posedge aclk);
      if (rst_ni) begin
        if (m_axi_awvalid && m_axi_awready) aw_q.push_back(m_axi_awaddr);
        if (m_axi_wvalid && m_axi_wready) begin
          if (m_axi_wlast !== ((w_q.size() % 16) == 15)) wlast_err++;
          w_q.push_back(m_axi_wdata);
          if (m_axi_wlast) b_owed++;
        end
        if (m_axi_bvalid && m_axi_bready) b_taken = 1'b1;
        if (s_valid_i && s_ready_o)  src_sent++;
        if (s_valid_i && !s_ready_o) tb_drop++;
      end
      @(negedge aclk);
      if (clr_req != clr_seen) begin
        clr_seen = clr_req;
        aw_q.delete(); w_q.delete();
        src_sent = 0; tb_drop = 0; wlast_err = 0; b_owed = 0; b_num = 0;
        b_taken = 1'b0; m_axi_bvalid = 1'b0;
      end
      if (b_taken) begin m_axi_bvalid = 1'b0; b_taken = 1'b0; b_num++; end
      if (!m_axi_bvalid && b_owed > 0) begin
        m_axi_bvalid = 1'b1;
        b_owed--;
        m_axi_bresp = (b_num == err_burst) ? 2'b10 : 2'b00;
      end
      m_axi_awready = aw_rand ? 1'($urandom_range(0, 1)) : aw_en;
      m_axi_wready  = w_rand  ? 1'($urandom_range(0, 1)) : w_en;
      s_valid_i     = src_on && (src_sent < src_limit);
      s_data_i      = tag_base + 64'(src_sent);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge aclk); #1; end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic cond_met(input int sel, input int arg);
    case (sel)
      0:       return !busy_o;
      1:       return m_axi_awvalid;
      2:       return m_axi_wvalid;
      default: return aw_q.size() >= arg;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int arg, input int maxc, input string tag);
    int n = 0;
    while (!cond_met(sel, arg) && n < maxc) begin tick(); n++; end
    check(tag, 64'(n < maxc), 64'd1);
  endtask

  task automatic clear_tb();
    src_on = 1'b0; src_limit = 0; clr_req++;
    tick(2);
  endtask

  task automatic pulse_start(input logic [31:0] base, input logic [19:0] num, input logic circ);
    base_addr_i = base; num_bursts_i = num; circ_i = circ; start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic check_data(input string tag, input int n);
    int errs = 0;
    check({tag, " count"}, 64'(w_q.size()), 64'(n));
    for (int i = 0; i < n && i < w_q.size(); i++)
      if (w_q[i] !== tag_base + 64'(i)) errs++;
    check({tag, " order"}, 64'(errs), 64'd0);
    check({tag, " wlast"}, 64'(wlast_err), 64'd0);
  endtask

  initial begin
    logic [63:0] d0;
    rst_ni = 1'b0; start_i = 1'b0; stop_i = 1'b0; circ_i = 1'b0;
    base_addr_i = '0; num_bursts_i = '0;
    tick(3);
    check("rst awvalid", 64'(m_axi_awvalid), 64'd0);
    check("rst wvalid",  64'(m_axi_wvalid),  64'd0);
    check("rst busy",    64'(busy_o),        64'd0);
    check("rst done",    64'(done_o),        64'd0);
    check("rst awaddr",  64'(m_axi_awaddr),  64'd0);
    check("rst sready",  64'(s_ready_o),     64'd1);
    rst_ni = 1'b1;
    tick(2);
    check("awlen",   64'(m_axi_awlen),   64'd15);
    check("awsize",  64'(m_axi_awsize),  64'd3);
    check("awburst", 64'(m_axi_awburst), 64'd1);
    check("wstrb",   64'(m_axi_wstrb),   64'hFF);

    // start with num_bursts = 0 is ignored
    pulse_start(32'h1234_0000, 20'd0, 1'b0);
    tick();
    check("zero start busy", 64'(busy_o), 64'd0);

    // 1: linear 4 bursts, FIFO prefilled before AW is allowed
    clear_tb();
    tag_base = 64'h1100_0000_0000_0000; aw_en = 1'b0; w_en = 1'b1;
    pulse_start(32'h1F00_0000, 20'd4, 1'b0);
    src_limit = 64; src_on = 1'b1;
    tick(70);
    check("t1 prefill", 64'(src_sent), 64'd64);
    check("t1 full sready", 64'(s_ready_o), 64'd0);
    check("t1 awvalid", 64'(m_axi_awvalid), 64'd1);
    aw_en = 1'b1;
    wait_for(0, 0, 1000, "t1 finish");
    check("t1 aw count", 64'(aw_q.size()), 64'd4);
    check("t1 aw0", 64'(aw_q[0]), 64'h1F00_0000);
    check("t1 aw1", 64'(aw_q[1]), 64'h1F00_0080);
    check("t1 aw2", 64'(aw_q[2]), 64'h1F00_0100);
    check("t1 aw3", 64'(aw_q[3]), 64'h1F00_0180);
    check_data("t1 data", 64);
    check("t1 done", 64'(done_o), 64'd1);
    check("t1 burst_cnt", 64'(burst_cnt_o), 64'd4);
    check("t1 drop", 64'(drop_cnt_o), 64'd0);

    // 2: AW gated until a full burst is buffered; start while busy ignored
    clear_tb();
    tag_base = 64'h2200_0000_0000_0000; aw_en = 1'b0;
    pulse_start(32'h1F00_1000, 20'd1, 1'b0);
    src_limit = 15; src_on = 1'b1;
    tick(25);
    pulse_start(32'h6000_0000, 20'd5, 1'b0);
    tick(25);
    check("t2 no awvalid", 64'(m_axi_awvalid), 64'd0);
    check("t2 busy", 64'(busy_o), 64'd1);
    src_limit = 16;
    tick();
    check("t2 awvalid", 64'(m_axi_awvalid), 64'd1);
    check("t2 awaddr", 64'(m_axi_awaddr), 64'h1F00_1000);
    aw_en = 1'b1;
    wait_for(0, 0, 500, "t2 finish");
    check_data("t2 data", 16);
    check("t2 burst_cnt", 64'(burst_cnt_o), 64'd1);

    // 3: circular 2 bursts, stop in the middle of the third burst
    clear_tb();
    tag_base = 64'h3300_0000_0000_0000;
    pulse_start(32'h1F10_0000, 20'd2, 1'b1);
    src_limit = 48; src_on = 1'b1;
    wait_for(3, 3, 500, "t3 third aw");
    tick(3);
    check("t3 mid burst", 64'(m_axi_wvalid), 64'd1);
    stop_i = 1'b1; tick(); stop_i = 1'b0;
    check("t3 busy after stop", 64'(busy_o), 64'd1);
    wait_for(0, 0, 500, "t3 finish");
    check("t3 aw count", 64'(aw_q.size()), 64'd3);
    check("t3 aw0", 64'(aw_q[0]), 64'h1F10_0000);
    check("t3 aw1", 64'(aw_q[1]), 64'h1F10_0080);
    check("t3 aw2", 64'(aw_q[2]), 64'h1F10_0000);
    check_data("t3 data", 48);
    check("t3 done", 64'(done_o), 64'd1);
    check("t3 burst_cnt", 64'(burst_cnt_o), 64'd1);

    // 4: AW/W held off 10 cycles, then random ready
    clear_tb();
    tag_base = 64'h4400_0000_0000_0000; aw_en = 1'b0; w_en = 1'b0;
    pulse_start(32'h2000_0000, 20'd3, 1'b0);
    src_limit = 48; src_on = 1'b1;
    wait_for(1, 0, 200, "t4 awvalid");
    tick(10);
    check("t4 aw held", 64'(m_axi_awvalid), 64'd1);
    check("t4 awaddr stable", 64'(m_axi_awaddr), 64'h2000_0000);
    aw_en = 1'b1;
    wait_for(2, 0, 200, "t4 wvalid");
    d0 = m_axi_wdata;
    check("t4 wdata head", d0, 64'h4400_0000_0000_0000);
    tick(10);
    check("t4 wdata stable", m_axi_wdata, 64'h4400_0000_0000_0000);
    check("t4 no beat", 64'(w_q.size()), 64'd0);
    aw_rand = 1'b1; w_rand = 1'b1;
    wait_for(0, 0, 3000, "t4 finish");
    aw_rand = 1'b0; w_rand = 1'b0; w_en = 1'b1;
    check("t4 aw2", 64'(aw_q[2]), 64'h2000_0100);
    check_data("t4 data", 48);

    // 5: W stalled 200 cycles with continuous stream -> 64 accepted, 136 dropped
    clear_tb();
    tag_base = 64'h5500_0000_0000_0000; aw_en = 1'b1; w_en = 1'b0;
    pulse_start(32'h3000_0000, 20'd4, 1'b0);
    src_limit = 1000000; src_on = 1'b1;
    tick(200);
    src_on = 1'b0;
    tick(2);
    check("t5 sready", 64'(s_ready_o), 64'd0);
    check("t5 accepted", 64'(src_sent), 64'd64);
    check("t5 drop_cnt", 64'(drop_cnt_o), 64'd136);
    check("t5 observed drops", 64'(tb_drop), 64'd136);
    w_en = 1'b1;
    wait_for(0, 0, 1000, "t5 finish");
    check_data("t5 data", 64);
    check("t5 done", 64'(done_o), 64'd1);

    // 6: SLVERR on the second B
    clear_tb();
    tag_base = 64'h6600_0000_0000_0000; err_burst = 1;
    pulse_start(32'h4000_0000, 20'd4, 1'b0);
    src_limit = 64; src_on = 1'b1;
    wait_for(0, 0, 1000, "t6 finish");
    tick(20);
`ifdef DMA_RESP_CHECK_EN
    check("t6 err", 64'(err_o), 64'd1);
    check("t6 done", 64'(done_o), 64'd0);
    check("t6 aw count", 64'(aw_q.size()), 64'd2);
    check("t6 burst_cnt", 64'(burst_cnt_o), 64'd1);
    check("t6 awaddr held", 64'(m_axi_awaddr), 64'h4000_0080);
`else
    check("t6 err tied", 64'(err_o), 64'd0);
    check("t6 done", 64'(done_o), 64'd1);
    check("t6 aw count", 64'(aw_q.size()), 64'd4);
    check("t6 burst_cnt", 64'(burst_cnt_o), 64'd4);
`endif
    err_burst = -1;

    // async reset in the middle of DATA
    clear_tb();
    tag_base = 64'h7700_0000_0000_0000; aw_en = 1'b1; w_en = 1'b0;
    pulse_start(32'h5000_0000, 20'd2, 1'b0);
    check("rst2 err cleared", 64'(err_o), 64'd0);
    src_limit = 32; src_on = 1'b1;
    wait_for(2, 0, 200, "rst2 in data");
    rst_ni = 1'b0;
    #1;
    check("rst2 wvalid", 64'(m_axi_wvalid), 64'd0);
    check("rst2 wlast", 64'(m_axi_wlast), 64'd0);
    check("rst2 busy", 64'(busy_o), 64'd0);
    check("rst2 awaddr", 64'(m_axi_awaddr), 64'd0);
    check("rst2 burst_cnt", 64'(burst_cnt_o), 64'd0);
    check("rst2 sready", 64'(s_ready_o), 64'd1);
    src_on = 1'b0;
    tick(2);
    rst_ni = 1'b1;
    clear_tb();
    check("rst2 idle", 64'(busy_o | done_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
